// File: rtl/gold_nic_pkg.sv
// Shared constants for the gold_nic PE<->router interface: register map,
// packet field positions, statistics layout and the VC polarity helper.
package gold_nic_pkg;

  localparam int ADDR_IN_BUF   = 0;
  localparam int ADDR_IN_STAT  = 1;
  localparam int ADDR_OUT_BUF  = 2;
  localparam int ADDR_OUT_STAT = 3;

  localparam int VC_BIT   = 63;
  localparam int HDIR_BIT = 62;
  localparam int VDIR_BIT = 61;
  localparam int HHOP_MSB = 58;
  localparam int HHOP_LSB = 55;
  localparam int VHOP_MSB = 54;
  localparam int VHOP_LSB = 51;
  localparam int SRC_MSB  = 31;
  localparam int SRC_LSB  = 16;
  localparam int DST_MSB  = 15;
  localparam int DST_LSB  = 0;

  localparam int CNT_W        = 16;
  localparam int STAT_INJ_LSB = 32;
  localparam int STAT_EJ_LSB  = 16;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } pe_access_e;

  // A packet may only leave on the cycle the router serves its virtual channel.
  function automatic logic vc_match(input logic i_vc, input logic i_polarity);
    return i_vc == i_polarity;
  endfunction

endpackage

// File: rtl/gold_nic_slot.sv
// Single-entry packet buffer with a full flag; load wins over clear.
module gold_nic_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_clear,
  output logic         o_full,
  output logic [W-1:0] o_data
);

  logic         r_full;
  logic [W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/gold_nic.sv
// Network interface between a PE and its gold_mesh router node.
// Optional injection/ejection counters are built when GOLD_NIC_STATS_EN is defined.
module gold_nic
  import gold_nic_pkg::*;
#(
  parameter int PACKET_SIZE = 64,
  parameter int ADDR_W      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [PACKET_SIZE-1:0] d_in,
  output logic [PACKET_SIZE-1:0] d_out,
  input  logic                   nicEn,
  input  logic                   nicWrEn,
  input  logic                   net_si,
  input  logic [PACKET_SIZE-1:0] net_di,
  output logic                   net_ro,
  output logic                   net_so,
  output logic [PACKET_SIZE-1:0] net_do,
  input  logic                   net_ri,
  input  logic                   net_polarity
);

  pe_access_e             w_access;
  logic                   w_in_full;
  logic [PACKET_SIZE-1:0] w_in_buf;
  logic                   w_out_full;
  logic [PACKET_SIZE-1:0] w_out_buf;
  logic                   w_accept;
  logic                   w_in_clear;
  logic                   w_out_load;
  logic                   w_xfer;
  logic [PACKET_SIZE-1:0] w_stat_ctr;
  logic [PACKET_SIZE-1:0] w_rd_data;
  logic                   r_net_ro;
  logic [PACKET_SIZE-1:0] r_d_out;

  always_comb begin
    w_access = ACC_NONE;
    if (nicEn) w_access = nicWrEn ? ACC_WRITE : ACC_READ;
  end

  assign w_accept   = net_si & r_net_ro;
  assign w_in_clear = (w_access == ACC_READ) && (addr == ADDR_W'(ADDR_IN_BUF)) && w_in_full;
  assign w_out_load = (w_access == ACC_WRITE) && (addr == ADDR_W'(ADDR_OUT_BUF)) && !w_out_full;
  assign w_xfer     = w_out_full & net_ri & vc_match(w_out_buf[VC_BIT], net_polarity);

  gold_nic_slot #(.W(PACKET_SIZE)) u_in_slot (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept),
    .i_data (net_di),
    .i_clear(w_in_clear),
    .o_full (w_in_full),
    .o_data (w_in_buf)
  );

  gold_nic_slot #(.W(PACKET_SIZE)) u_out_slot (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_out_load),
    .i_data (d_in),
    .i_clear(w_xfer),
    .o_full (w_out_full),
    .o_data (w_out_buf)
  );

  // Ready lags the full flag by one cycle, so it is low right after reset release.
  always_ff @(posedge clk) begin
    if (!reset) r_net_ro <= 1'b0;
    else        r_net_ro <= ~w_in_full;
  end

`ifdef GOLD_NIC_STATS_EN
  logic [CNT_W-1:0] r_inj_cnt;
  logic [CNT_W-1:0] r_ej_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_inj_cnt <= '0;
      r_ej_cnt  <= '0;
    end else begin
      if (w_xfer)   r_inj_cnt <= r_inj_cnt + CNT_W'(1);
      if (w_accept) r_ej_cnt  <= r_ej_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_stat_ctr = '0;
    w_stat_ctr[STAT_INJ_LSB +: CNT_W] = r_inj_cnt;
    w_stat_ctr[STAT_EJ_LSB +: CNT_W]  = r_ej_cnt;
  end
`else
  assign w_stat_ctr = '0;
`endif

  always_comb begin
    w_rd_data = '0;
    case (addr)
      ADDR_W'(ADDR_IN_BUF):   w_rd_data = w_in_buf;
      ADDR_W'(ADDR_IN_STAT):  w_rd_data = w_stat_ctr | {{(PACKET_SIZE-1){1'b0}}, w_in_full};
      ADDR_W'(ADDR_OUT_STAT): w_rd_data = w_stat_ctr | {{(PACKET_SIZE-1){1'b0}}, w_out_full};
      default:                w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)                      r_d_out <= '0;
    else if (w_access == ACC_READ)   r_d_out <= w_rd_data;
  end

  assign d_out  = r_d_out;
  assign net_ro = r_net_ro;
  assign net_so = w_xfer;
  assign net_do = w_out_buf;

endmodule

// File: tb/tb_gold_nic.sv
// Directed table-driven bench for gold_nic; counter checks are added when
// GOLD_NIC_STATS_EN is defined.
module tb_gold_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn, nicWrEn;
  logic        net_si;
  logic [63:0] net_di;
  logic        net_ro, net_so;
  logic [63:0] net_do;
  logic        net_ri, net_polarity;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] P1 = 64'h0000_0000_0000_000F;
  localparam logic [63:0] P2 = 64'h8000_0000_0000_00F0;
  localparam logic [63:0] PA = 64'h0000_0000_0000_1234;
  localparam logic [63:0] PB = 64'h0000_0000_0000_5678;
  localparam logic [63:0] PC = 64'h8000_0000_0000_0001;
  localparam logic [63:0] PD = 64'h0000_0000_0000_0099;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef GOLD_NIC_STATS_EN
  localparam logic [63:0] DMASK = 64'hFFFF_0000_0000_FFFF;
`else
  localparam logic [63:0] DMASK = ALL;
`endif

  gold_nic dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_di(net_di),
    .net_ro(net_ro), .net_so(net_so), .net_do(net_do), .net_ri(net_ri),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, wr;
    logic [1:0]  a;
    logic [63:0] din;
    logic        si;
    logic [63:0] di;
    logic        ri, pol;
    logic        exp_so;
    logic [63:0] exp_do;
    logic        exp_ro;
    logic [63:0] exp_dout;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(logic en, logic wr, logic [1:0] a, logic [63:0] din,
                              logic si, logic [63:0] di, logic ri, logic pol,
                              logic so, logic [63:0] dov, logic ro, logic [63:0] dout);
    vec_t v;
    v.en = en; v.wr = wr; v.a = a; v.din = din; v.si = si; v.di = di;
    v.ri = ri; v.pol = pol; v.exp_so = so; v.exp_do = dov; v.exp_ro = ro; v.exp_dout = dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp,
                     input logic [63:0] mask);
    n_tests++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act & mask, exp & mask);
    end
  endtask

  task automatic idle_inputs();
    nicEn = 0; nicWrEn = 0; addr = 0; d_in = 0; net_si = 0; net_di = 0;
  endtask

  // Entered and left at a falling edge.
  task automatic rd(input logic [1:0] a, input logic [63:0] exp, input logic [63:0] mask,
                    input string name);
    nicEn = 1; nicWrEn = 0; addr = a;
    @(posedge clk); #1;
    chk(name, d_out, exp, mask);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic inject(input logic [63:0] pkt);
    nicEn = 1; nicWrEn = 1; addr = 2; d_in = pkt;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic eject(input logic [63:0] pkt);
    net_si = 1; net_di = pkt;
    @(negedge clk);
    idle_inputs();
    nicEn = 1; addr = 0;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = mk(0,0,0,0,  0,0,  0,0, 0,0,  1,0);
    tbl[1]  = mk(1,0,1,0,  0,0,  0,0, 0,0,  1,0);
    tbl[2]  = mk(1,0,3,0,  0,0,  0,0, 0,0,  1,0);
    tbl[3]  = mk(1,1,2,P1, 0,0,  1,1, 0,0,  1,0);
    tbl[4]  = mk(0,0,0,0,  0,0,  1,1, 0,P1, 1,0);
    tbl[5]  = mk(0,0,0,0,  0,0,  1,1, 0,P1, 1,0);
    tbl[6]  = mk(0,0,0,0,  0,0,  1,1, 0,P1, 1,0);
    tbl[7]  = mk(0,0,0,0,  0,0,  1,0, 1,P1, 1,0);
    tbl[8]  = mk(1,0,3,0,  0,0,  1,0, 0,P1, 1,0);
    tbl[9]  = mk(0,0,0,0,  1,P2, 1,0, 0,P1, 1,0);
    tbl[10] = mk(1,0,1,0,  0,0,  1,0, 0,P1, 0,1);
    tbl[11] = mk(0,0,0,0,  1,P1, 1,0, 0,P1, 0,1);
    tbl[12] = mk(1,0,0,0,  0,0,  1,0, 0,P1, 0,P2);
    tbl[13] = mk(0,0,0,0,  0,0,  1,0, 0,P1, 1,P2);
    tbl[14] = mk(1,0,1,0,  0,0,  1,0, 0,P1, 1,0);
    tbl[15] = mk(1,0,0,0,  0,0,  1,0, 0,P1, 1,P2);
    tbl[16] = mk(1,1,0,P1, 0,0,  1,0, 0,P1, 1,P2);
    tbl[17] = mk(1,1,3,ALL,0,0,  1,0, 0,P1, 1,P2);
    tbl[18] = mk(1,0,0,0,  0,0,  1,0, 0,P1, 1,P2);
    tbl[19] = mk(1,0,2,0,  0,0,  1,0, 0,P1, 1,0);
    tbl[20] = mk(1,1,2,PA, 0,0,  0,0, 0,P1, 1,0);
    tbl[21] = mk(1,1,2,PB, 0,0,  0,0, 0,PA, 1,0);
    tbl[22] = mk(1,0,3,0,  0,0,  0,0, 0,PA, 1,1);
    tbl[23] = mk(0,0,0,0,  0,0,  1,0, 1,PA, 1,1);
    tbl[24] = mk(1,0,3,0,  0,0,  1,0, 0,PA, 1,0);
    tbl[25] = mk(1,1,2,PC, 0,0,  0,0, 0,PA, 1,0);
    tbl[26] = mk(1,1,2,PD, 0,0,  1,1, 1,PC, 1,0);
    tbl[27] = mk(1,0,3,0,  0,0,  1,1, 0,PC, 1,0);
    tbl[28] = mk(0,0,0,0,  0,0,  0,0, 0,PC, 1,0);

    idle_inputs();
    net_ri = 0; net_polarity = 0;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ro",   {63'b0, net_ro}, 0, ALL);
    chk("rst_so",   {63'b0, net_so}, 0, ALL);
    chk("rst_dout", d_out, 0, ALL);
    chk("rst_do",   net_do, 0, ALL);
    @(negedge clk);
    reset = 1;
    #1;
    chk("rel_ro_low", {63'b0, net_ro}, 0, ALL);
    @(negedge clk);
    // Vector loop is entered with the first released edge still ahead.
    for (int i = 0; i < 29; i++) begin
      if (i == 0) begin
        // realign: the loop expects to start one negedge after release
      end
    end
    for (int i = 0; i < 29; i++) begin
      nicEn = tbl[i].en; nicWrEn = tbl[i].wr; addr = tbl[i].a; d_in = tbl[i].din;
      net_si = tbl[i].si; net_di = tbl[i].di; net_ri = tbl[i].ri; net_polarity = tbl[i].pol;
      #1;
      chk($sformatf("v%0d_so", i), {63'b0, net_so}, {63'b0, tbl[i].exp_so}, ALL);
      chk($sformatf("v%0d_do", i), net_do, tbl[i].exp_do, ALL);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ro", i), {63'b0, net_ro}, {63'b0, tbl[i].exp_ro}, ALL);
      chk($sformatf("v%0d_dout", i), d_out, tbl[i].exp_dout, DMASK);
      @(negedge clk);
    end

    // Reset with both buffers holding packets discards them.
    idle_inputs();
    net_ri = 0; net_polarity = 0;
    nicEn = 1; nicWrEn = 1; addr = 2; d_in = 64'h0000_0000_0000_0E0E;
    net_si = 1; net_di = 64'h0000_0000_0000_0F0F;
    @(negedge clk);
    idle_inputs();
    net_ri = 1;
    reset = 0;
    #1;
    chk("mid_so_before", {63'b0, net_so}, 1, ALL);
    @(posedge clk); #1;
    chk("mid_so_after", {63'b0, net_so}, 0, ALL);
    chk("mid_do_after", net_do, 0, ALL);
    chk("mid_ro_after", {63'b0, net_ro}, 0, ALL);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mid_ro_back", {63'b0, net_ro}, 1, ALL);
    rd(1, 0, DMASK, "mid_in_stat");
    rd(3, 0, DMASK, "mid_out_stat");
    rd(0, 0, ALL, "mid_in_buf");
    chk("mid_do_clean", net_do, 0, ALL);
    chk("mid_so_clean", {63'b0, net_so}, 0, ALL);

`ifdef GOLD_NIC_STATS_EN
    net_ri = 1; net_polarity = 0;
    for (int k = 0; k < 3; k++) inject(64'h0000_0000_0000_0100 + 64'(k));
    for (int k = 0; k < 2; k++) eject(64'h0000_0000_0000_0200 + 64'(k));
    rd(1, 64'h0000_0003_0002_0000, ALL, "stat_in_cnt");
    rd(3, 64'h0000_0003_0002_0000, ALL, "stat_out_cnt");
    for (int k = 0; k < 65532; k++) inject(64'h0000_0000_0000_0300);
    rd(3, 64'h0000_FFFF_0002_0000, ALL, "stat_ffff");
    inject(64'h0000_0000_0000_0301);
    rd(3, 64'h0000_0000_0002_0000, ALL, "stat_wrap");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gold_nic.md
Name: gold_nic

Overview:
- Network interface controller that sits between a processing element (PE) and its gold_mesh router node.
- Drives the node's pesi/pedi inputs and checks peri. Consumes the node's peso/pedo outputs and drives pero.
- Exposes the link to the PE as four 64-bit memory-mapped registers: input buffer, input status, output buffer, output status.
- One instance per mesh node, 16 per 4×4 mesh.

Parameters:
- PACKET_SIZE, 64, packet/data width in bits.
- ADDR_W, 2, register address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; block is in reset in any cycle where reset==0 at the rising edge.
- addr  in  ADDR_W  PE register select: 0=in_buf, 1=in_status, 2=out_buf, 3=out_status.
- d_in  in  PACKET_SIZE  PE write data.
- d_out  out  PACKET_SIZE  PE read data, registered.
- nicEn  in  1  PE access strobe.
- nicWrEn  in  1  1=write, 0=read; valid only with nicEn.
- net_si  in  1  router→NIC send (from node peso).
- net_di  in  PACKET_SIZE  router→NIC packet (from node pedo).
- net_ro  out  1  NIC ready to accept (to node pero).
- net_so  out  1  NIC→router send (to node pesi).
- net_do  out  PACKET_SIZE  NIC→router packet (to node pedi).
- net_ri  in  1  router ready (from node peri).
- net_polarity  in  1  router's current VC polarity.

Behaviour:
- Reset values: in_buf=0, in_full=0, out_buf=0, out_full=0, d_out=0, net_ro=0, net_so=0, net_do=0.
- Reset dominates every other event in the same cycle, including mid-transfer: buffered packets are discarded.
- Packet field positions (shared package):
  - VC bit [63].
  - hdir [62], vdir [61].
  - reserved [60:59].
  - hhop [58:55], vhop [54:51].
  - src [31:16], dst [15:0].
- The NIC never modifies packet contents.
- Input channel (single-entry buffer):
  - net_ro is registered and equals ~in_full of the previous cycle, so it is low in the cycle after reset release.
  - Acceptance: if net_si & net_ro at an edge, then in_buf<=net_di and in_full<=1.
  - net_si while net_ro==0 is ignored; the router holds the packet.
  - PE read of addr 0 when in_full=1: d_out<=in_buf and in_full<=0. net_ro rises one cycle later.
  - PE read of addr 0 when in_full=0: d_out<=in_buf (stale), flags unchanged.
  - Acceptance and clear cannot coincide, because net_ro is low while in_full is set.
- Output channel (single-entry buffer):
  - PE write of addr 2 when out_full=0: out_buf<=d_in and out_full<=1.
  - PE write of addr 2 when out_full=1 is dropped silently.
  - net_do = out_buf (registered, combinational pass-through).
  - net_so = out_full & net_ri & (out_buf[63]==net_polarity), combinational.
  - At an edge where net_so=1, the transfer completes and out_full<=0.
  - Earliest re-inject is two cycles after the load write: load, clear, then load.
  - A write in the same cycle as a transfer is dropped, because out_full is still 1 at that edge.
- Status reads:
  - addr 1: d_out<={63'b0, in_full}.
  - addr 3: d_out<={63'b0, out_full}.
  - addr 2 read: d_out<=0.
- Writes to addr 0, 1 and 3 are ignored.
- d_out updates only on reads (nicEn & ~nicWrEn), one-cycle latency, and holds otherwise.
- nicEn=0 means no PE access; nicWrEn is don't-care.

Optional Feature:
- Macro: GOLD_NIC_STATS_EN.
- When defined:
  - Two 16-bit wrapping counters: inj_cnt (+1 per net_so transfer) and ej_cnt (+1 per input acceptance).
  - Status reads return the counters in bits [47:32]=inj_cnt and [31:16]=ej_cnt; bit 0 is unchanged.
  - Counters reset to 0.
  - Counter value 0xFFFF wraps to 0x0000.
- When undefined: those status bits read 0 and no counter flops exist.

Decomposition:
- Package gold_nic_pkg holds:
  - Address constants ADDR_IN_BUF=0, ADDR_IN_STAT=1, ADDR_OUT_BUF=2, ADDR_OUT_STAT=3.
  - Packet field index constants (VC_BIT, HDIR_BIT, VDIR_BIT, HHOP_MSB/LSB, VHOP_MSB/LSB, SRC_MSB/LSB, DST_MSB/LSB).
  - Counter width 16.
- One sub-module, gold_nic_slot: a single-entry buffer with full flag, load and clear ports. Instantiated twice (input and output channels).
- Polarity gate, register decode and counters live in the top module.

Test Plan:
- Reset → after reset==0 at an edge: net_ro=0, net_so=0, d_out=0. One cycle after release: net_ro=1. Status reads at addr 1 and addr 3 return 0.
- Inject 0x0000_0000_0000_000F on a VC0 packet:
  - Write addr 2.
  - Hold net_ri=1 and net_polarity=1 for 3 cycles: net_so stays 0.
  - Set net_polarity=0: net_so=1 and net_do equals the packet for one cycle.
  - Status at addr 3 then reads 0.
- Eject 0x8000_0000_0000_00F0:
  - Drive net_si=1 with that value: in_full=1 and net_ro falls next cycle.
  - A second net_si packet is ignored while full.
  - Read addr 0: d_out=0x8000_0000_0000_00F0; net_ro=1 two cycles after the read.
- Write-while-full: write A, then B with net_ri=0 → only A is ever seen on net_do; status at addr 3=1 until A transfers.
- Reset mid-operation: in_full=1 and out_full=1, then assert reset for 1 cycle → both flags 0, net_so=0, and the buffered packets never appear.
- With GOLD_NIC_STATS_EN defined: 3 injects and 2 ejects → status bits [47:32]=3 and [31:16]=2. Preload the counter to 0xFFFF via 65535 injects, inject once more → reads 0.
